// File: rtl/bomb_sequencer_if.sv
// rtl/bomb_sequencer_if.sv - Bus bundle between the top level and the bomb sequencer

interface bomb_sequencer_if;
  logic       frame_vs;
  logic [7:0] keycode;
  logic       Detonate;
  logic [9:0] playerX;
  logic [9:0] playerY;
  logic [9:0] BombX;
  logic [9:0] BombY;
  logic       Bomb_On;
  logic       Blast_On;
  logic [2:0] Blast_Radius;
  logic       Busy;
  logic [1:0] State;

  // Top level / stimulus side: drives player and key inputs, observes bomb outputs.
  modport master (
    output frame_vs, keycode, Detonate, playerX, playerY,
    input  BombX, BombY, Bomb_On, Blast_On, Blast_Radius, Busy, State
  );

  // Sequencer side.
  modport slave (
    input  frame_vs, keycode, Detonate, playerX, playerY,
    output BombX, BombY, Bomb_On, Blast_On, Blast_Radius, Busy, State
  );
endinterface

// File: rtl/bomb_sequencer.sv
// rtl/bomb_sequencer.sv - Frame-synchronous bomb place/fuse/blast/cooldown sequencer

module bomb_sequencer #(
  parameter logic [7:0] PLACE_KEY       = 8'h2C,
  parameter int         FUSE_FRAMES     = 120,
  parameter int         BLAST_FRAMES    = 30,
  parameter int         COOLDOWN_FRAMES = 20,
  parameter int         TILE_SHIFT      = 5,
  parameter int         MAX_RADIUS      = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  bomb_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    BLAST    = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam int MAX_FRAMES_FB = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
  localparam int MAX_FRAMES    = (MAX_FRAMES_FB > COOLDOWN_FRAMES) ? MAX_FRAMES_FB : COOLDOWN_FRAMES;
  // A single-frame configuration still needs a 1-bit counter.
  localparam int CNT_W         = ($clog2(MAX_FRAMES) < 1) ? 1 : $clog2(MAX_FRAMES);

  localparam logic [CNT_W-1:0] FUSE_LOAD     = CNT_W'(FUSE_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLAST_LOAD    = CNT_W'(BLAST_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOLDOWN_LOAD = CNT_W'(COOLDOWN_FRAMES - 1);

  localparam logic [10:0] TILE_HALF = 11'(1 << (TILE_SHIFT - 1));
  localparam logic [10:0] TILE_SIZE = 11'(1 << TILE_SHIFT);
  localparam logic [10:0] X_LIMIT   = 11'd640 - TILE_SIZE;
  localparam logic [10:0] Y_LIMIT   = 11'd480 - TILE_SIZE;
  localparam logic [2:0]  RAD_MAX   = 3'(MAX_RADIUS);

  // Frame-edge synchroniser and history flop.
  logic s1, s2, s3;
  logic tick;

  // Registered state and outputs.
  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             key_armed_q, key_armed_n;
  logic [9:0]       bomb_x_q, bomb_x_n;
  logic [9:0]       bomb_y_q, bomb_y_n;
  logic             bomb_on_q, bomb_on_n;
  logic             blast_on_q, blast_on_n;
  logic [2:0]       radius_q, radius_n;

  // Grid snap of the player position.
  logic [10:0] sum_x, sum_y;
  logic [10:0] raw_x, raw_y;
  logic [9:0]  snap_x, snap_y;
  logic        place_req;

  assign tick = s2 & ~s3;

  // Bring the asynchronous VGA_VS into the Clk domain and keep one cycle of history for edge detect.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.frame_vs;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Round to the nearest tile origin, then keep the whole tile on screen.
  always_comb begin
    sum_x  = {1'b0, bus.playerX} + TILE_HALF;
    sum_y  = {1'b0, bus.playerY} + TILE_HALF;
    raw_x  = (sum_x >> TILE_SHIFT) << TILE_SHIFT;
    raw_y  = (sum_y >> TILE_SHIFT) << TILE_SHIFT;
    snap_x = (raw_x > X_LIMIT) ? X_LIMIT[9:0] : raw_x[9:0];
    snap_y = (raw_y > Y_LIMIT) ? Y_LIMIT[9:0] : raw_y[9:0];
  end

  assign place_req = (bus.keycode == PLACE_KEY) && key_armed_q;

  // Next-state and next-output decode; nothing moves except on a frame tick.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    key_armed_n = key_armed_q;
    bomb_x_n    = bomb_x_q;
    bomb_y_n    = bomb_y_q;
    bomb_on_n   = bomb_on_q;
    blast_on_n  = blast_on_q;
    radius_n    = radius_q;

    if (tick) begin
      // Any frame without the place key re-arms it, whatever phase we are in.
      if (bus.keycode != PLACE_KEY) begin
        key_armed_n = 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (place_req) begin
            state_n     = ARMED;
            key_armed_n = 1'b0;
            cnt_n       = FUSE_LOAD;
            bomb_x_n    = snap_x;
            bomb_y_n    = snap_y;
            bomb_on_n   = 1'b1;
          end
        end

        ARMED: begin
          // Fuse expiry and chain detonation share one entry path, so both at once act once.
          if ((cnt_q == '0) || bus.Detonate) begin
            state_n    = BLAST;
            cnt_n      = BLAST_LOAD;
            bomb_on_n  = 1'b0;
            blast_on_n = 1'b1;
            radius_n   = 3'd1;
          end else begin
            cnt_n = cnt_q - 1'b1;
          end
        end

        BLAST: begin
          if (cnt_q == '0) begin
            state_n    = COOLDOWN;
            cnt_n      = COOLDOWN_LOAD;
            blast_on_n = 1'b0;
            radius_n   = 3'd0;
          end else begin
            cnt_n    = cnt_q - 1'b1;
            radius_n = (radius_q >= RAD_MAX) ? RAD_MAX : radius_q + 3'd1;
          end
        end

        COOLDOWN: begin
          if (cnt_q == '0) begin
            state_n = IDLE;
          end else begin
            cnt_n = cnt_q - 1'b1;
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State, counter and output registers; reset aborts any phase at once.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_armed_q <= 1'b0;
      bomb_x_q    <= '0;
      bomb_y_q    <= '0;
      bomb_on_q   <= 1'b0;
      blast_on_q  <= 1'b0;
      radius_q    <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      key_armed_q <= key_armed_n;
      bomb_x_q    <= bomb_x_n;
      bomb_y_q    <= bomb_y_n;
      bomb_on_q   <= bomb_on_n;
      blast_on_q  <= blast_on_n;
      radius_q    <= radius_n;
    end
  end

  assign bus.BombX        = bomb_x_q;
  assign bus.BombY        = bomb_y_q;
  assign bus.Bomb_On      = bomb_on_q;
  assign bus.Blast_On     = blast_on_q;
  assign bus.Blast_Radius = radius_q;
  assign bus.State        = state_q;
  assign bus.Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bomb_sequencer.sv
// tb/tb_bomb_sequencer.sv - Scoreboard bench for the bomb sequencer

module tb_bomb_sequencer;

  logic clk;
  logic reset;

  bomb_sequencer_if bus ();

  bomb_sequencer #(
    .PLACE_KEY      (8'h2C),
    .FUSE_FRAMES    (4),
    .BLAST_FRAMES   (3),
    .COOLDOWN_FRAMES(2),
    .TILE_SHIFT     (5),
    .MAX_RADIUS     (2)
  ) dut (
    .Clk  (clk),
    .Reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] vec;
  } exp_t;

  exp_t sb[$];
  int   n_vectors;
  int   n_miscompares;

  function automatic logic [31:0] pack(input logic [1:0] st, input logic bon, input logic blon,
                                       input logic [2:0] rad, input logic [9:0] bx, input logic [9:0] by);
    logic busy;
    busy = (st != 2'd0);
    return {4'b0, st, busy, bon, blon, rad, bx, by};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s got=%h exp=%h (fmt st,busy,bon,blon,rad,bx,by)", tag, got, exp);
    end
  endtask

  task automatic pop_and_check();
    exp_t        e;
    logic [31:0] got;
    got = pack(bus.State, bus.Bomb_On, bus.Blast_On, bus.Blast_Radius, bus.BombX, bus.BombY);
    got[25] = bus.Busy;
    if (sb.size() == 0) begin
      n_vectors++;
      n_miscompares++;
      $display("FAIL scoreboard_empty got=%h exp=none", got);
    end else begin
      e = sb.pop_front();
      check_vec(e.tag, got, e.vec);
    end
  endtask

  // One frame: drive inputs, pulse frame_vs for width cycles, let the tick land, compare.
  task automatic step(input string tag, input logic [7:0] kc, input logic det,
                      input logic [9:0] px, input logic [9:0] py, input int width,
                      input logic [1:0] st, input logic bon, input logic blon,
                      input logic [2:0] rad, input logic [9:0] bx, input logic [9:0] by);
    exp_t e;
    e.tag = tag;
    e.vec = pack(st, bon, blon, rad, bx, by);
    sb.push_back(e);
    @(posedge clk); #1;
    bus.keycode  = kc;
    bus.Detonate = det;
    bus.playerX  = px;
    bus.playerY  = py;
    bus.frame_vs = 1'b1;
    repeat (width) @(posedge clk);
    #1 bus.frame_vs = 1'b0;
    repeat (5) @(posedge clk);
    #1 pop_and_check();
  endtask

  task automatic pulse_reset(input string tag);
    exp_t e;
    e.tag = tag;
    e.vec = pack(2'd0, 1'b0, 1'b0, 3'd0, 10'd0, 10'd0);
    sb.push_back(e);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    pop_and_check();
  endtask

  localparam logic [7:0] K = 8'h2C;
  localparam logic [7:0] N = 8'h00;

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    reset         = 1'b1;
    bus.frame_vs  = 1'b0;
    bus.keycode   = K;
    bus.Detonate  = 1'b0;
    bus.playerX   = 10'd100;
    bus.playerY   = 10'd50;
    repeat (3) @(posedge clk);
    pulse_reset("reset_state");

    // Key held through reset must not place.
    step("held_idle_a",  K, 0, 100, 50, 1, 2'd0, 0, 0, 3'd0, 10'd0,  10'd0);
    step("held_idle_b",  K, 0, 100, 50, 3, 2'd0, 0, 0, 3'd0, 10'd0,  10'd0);
    step("release",      N, 0, 100, 50, 1, 2'd0, 0, 0, 3'd0, 10'd0,  10'd0);
    step("place",        K, 0, 100, 50, 1, 2'd1, 1, 0, 3'd0, 10'd96, 10'd64);
    step("armed_1",      K, 0, 100, 50, 4, 2'd1, 1, 0, 3'd0, 10'd96, 10'd64);
    step("armed_2",      K, 0, 100, 50, 1, 2'd1, 1, 0, 3'd0, 10'd96, 10'd64);
    step("armed_3",      K, 0, 100, 50, 1, 2'd1, 1, 0, 3'd0, 10'd96, 10'd64);
    step("blast_r1",     K, 0, 100, 50, 1, 2'd2, 0, 1, 3'd1, 10'd96, 10'd64);
    step("blast_r2",     K, 0, 100, 50, 2, 2'd2, 0, 1, 3'd2, 10'd96, 10'd64);
    step("blast_sat",    K, 0, 100, 50, 1, 2'd2, 0, 1, 3'd2, 10'd96, 10'd64);
    step("cool_1",       K, 0, 100, 50, 1, 2'd3, 0, 0, 3'd0, 10'd96, 10'd64);
    step("cool_2",       K, 0, 100, 50, 1, 2'd3, 0, 0, 3'd0, 10'd96, 10'd64);
    step("back_idle",    K, 0, 100, 50, 1, 2'd0, 0, 0, 3'd0, 10'd96, 10'd64);
    step("still_held",   K, 0, 100, 50, 1, 2'd0, 0, 0, 3'd0, 10'd96, 10'd64);
    step("det_in_idle",  N, 1, 100, 50, 1, 2'd0, 0, 0, 3'd0, 10'd96, 10'd64);

    // Clamped placement and early detonation on the second ARMED tick.
    step("place_clamp",  K, 0, 630, 475, 1, 2'd1, 1, 0, 3'd0, 10'd608, 10'd448);
    step("armed_c1",     K, 0, 630, 475, 1, 2'd1, 1, 0, 3'd0, 10'd608, 10'd448);
    step("det_early",    K, 1, 630, 475, 1, 2'd2, 0, 1, 3'd1, 10'd608, 10'd448);
    step("det_in_blast", N, 1, 100, 50,  1, 2'd2, 0, 1, 3'd2, 10'd608, 10'd448);
    step("press_blast",  K, 0, 100, 50,  1, 2'd2, 0, 1, 3'd2, 10'd608, 10'd448);
    step("cool_c1",      K, 0, 100, 50,  1, 2'd3, 0, 0, 3'd0, 10'd608, 10'd448);
    step("cool_c2",      K, 0, 100, 50,  1, 2'd3, 0, 0, 3'd0, 10'd608, 10'd448);
    step("idle_c",       K, 0, 100, 50,  1, 2'd0, 0, 0, 3'd0, 10'd608, 10'd448);
    step("place_first",  K, 0, 100, 50,  1, 2'd1, 1, 0, 3'd0, 10'd96,  10'd64);

    // Detonate coinciding with fuse expiry enters BLAST once.
    step("armed_d1",     K, 0, 100, 50, 1, 2'd1, 1, 0, 3'd0, 10'd96, 10'd64);
    step("armed_d2",     K, 0, 100, 50, 1, 2'd1, 1, 0, 3'd0, 10'd96, 10'd64);
    step("armed_d3",     K, 0, 100, 50, 1, 2'd1, 1, 0, 3'd0, 10'd96, 10'd64);
    step("det_and_zero", K, 1, 100, 50, 1, 2'd2, 0, 1, 3'd1, 10'd96, 10'd64);
    step("blast_after",  K, 0, 100, 50, 1, 2'd2, 0, 1, 3'd2, 10'd96, 10'd64);

    // Reset during BLAST with the key held.
    pulse_reset("reset_mid_blast");
    step("post_rst_held", K, 0, 100, 50, 1, 2'd0, 0, 0, 3'd0, 10'd0,  10'd0);
    step("post_rst_rel",  N, 0, 100, 50, 1, 2'd0, 0, 0, 3'd0, 10'd0,  10'd0);
    step("post_rst_place",K, 0, 100, 50, 1, 2'd1, 1, 0, 3'd0, 10'd96, 10'd64);
    step("post_rst_arm",  K, 0, 100, 50, 6, 2'd1, 1, 0, 3'd0, 10'd96, 10'd64);

    if (sb.size() != 0) begin
      n_vectors++;
      n_miscompares++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/bomb_sequencer.md
Name: bomb_sequencer

Overview:
- Frame-synchronous controller that sequences the bomb resource: accepts a place request from the USB keycode, snaps the bomb to the tile grid under the player, and runs the fuse, blast and cooldown phases.
- Drives BombX, BombY, Bomb_On into color_mapper, plus blast outputs for the renderer and collision logic.
- Sits at top level alongside ball/background and replaces the free-running bomb module.

Parameters:
- PLACE_KEY, 8'h2C, USB HID keycode that places a bomb (space).
- FUSE_FRAMES, 120, frames the bomb is armed before exploding (≥1).
- BLAST_FRAMES, 30, frames the blast is displayed (≥1).
- COOLDOWN_FRAMES, 20, frames after the blast before a new placement is accepted (≥1).
- TILE_SHIFT, 5, log2 of the tile size in pixels (32).
- MAX_RADIUS, 3, saturating blast radius in tiles (1..7).

Ports:
- Clk  input  1  50 MHz system clock (MAX10_CLK1_50).
- Reset  input  1  synchronous, active-high.
- frame_vs  input  1  raw VGA_VS; treated as asynchronous.
- keycode  input  8  current USB keycode.
- Detonate  input  1  level; forces early explosion (chain reaction).
- playerX  input  10  player X pixel.
- playerY  input  10  player Y pixel.
- BombX  output  10  snapped bomb X.
- BombY  output  10  snapped bomb Y.
- Bomb_On  output  1  bomb sprite visible.
- Blast_On  output  1  blast active.
- Blast_Radius  output  3  current blast radius in tiles.
- Busy  output  1  state != IDLE.
- State  output  2  IDLE=0, ARMED=1, BLAST=2, COOLDOWN=3.

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE; all outputs 0.
  - Counters 0; sync flops 0.
  - key_armed=0, so a key held through reset does not place a bomb until it is released.
  - Reset asserted mid-operation aborts immediately with the same result.
- Frame tick:
  - frame_vs passes through 2 flops (s1, s2) plus a history flop s3.
  - tick = s2 & ~s3: one Clk cycle wide, 2 cycles after the rising edge of frame_vs is first sampled.
  - All state transitions, counters and key sampling occur only on cycles where tick=1. Outputs are registered and change on the Clk edge that consumes the tick.
- Key tracking (every tick, in any state): if keycode != PLACE_KEY then key_armed ← 1.
- Place request: keycode == PLACE_KEY and key_armed == 1.
- Grid snap: computed in 11-bit arithmetic.
  - sx = ((playerX + 2^(TILE_SHIFT-1)) >> TILE_SHIFT) << TILE_SHIFT; clamp to 640 − 2^TILE_SHIFT if larger.
  - sy: same formula with playerY, clamped to 480 − 2^TILE_SHIFT.
  - BombX/BombY are latched only on placement and hold until the next placement; they are not cleared in COOLDOWN.
- FSM (evaluated on tick only):
  - IDLE, place request:
    - → ARMED; key_armed ← 0; cnt ← FUSE_FRAMES−1.
    - BombX ← sx; BombY ← sy; Bomb_On ← 1.
  - IDLE, Detonate: ignored.
  - ARMED, cnt==0 or Detonate:
    - → BLAST; cnt ← BLAST_FRAMES−1.
    - Bomb_On ← 0; Blast_On ← 1; Blast_Radius ← 1.
  - ARMED, otherwise: cnt ← cnt−1.
  - BLAST, cnt==0:
    - → COOLDOWN; cnt ← COOLDOWN_FRAMES−1.
    - Blast_On ← 0; Blast_Radius ← 0.
  - BLAST, otherwise: cnt ← cnt−1; Blast_Radius ← min(Blast_Radius+1, MAX_RADIUS).
  - COOLDOWN, cnt==0: → IDLE.
  - COOLDOWN, otherwise: cnt ← cnt−1.
- Phase durations:
  - Bomb_On high for exactly FUSE_FRAMES ticks, or fewer if Detonate.
  - Blast_On high for exactly BLAST_FRAMES ticks.
  - IDLE re-entered COOLDOWN_FRAMES ticks after the blast ends.
- Presses in ARMED, BLAST or COOLDOWN are dropped, not queued.
  - Release-then-press during those states leaves key_armed=1.
  - If the key is still held on the first IDLE tick, the bomb places on that tick.
- Detonate and cnt==0 on the same tick: single BLAST entry; no double effect.
- cnt width: clog2 of the largest frame parameter.

Test Plan:
- Params FUSE=4, BLAST=3, COOLDOWN=2, MAX_RADIUS=2; Reset; playerX=100, playerY=50; keycode 0x00 one tick, then 0x2C → next tick State=1, BombX=96, BombY=64, Bomb_On=1 for 4 ticks.
- Same run continued → Blast_On=1 for 3 ticks with Blast_Radius 1,2,2; then State=3 for 2 ticks; then State=0, Busy=0.
- playerX=630, playerY=475 at placement → BombX=608, BombY=448 (clamped).
- Hold keycode 0x2C from reset through a full cycle → no placement; release one tick, press → placement on the next tick.
- Assert Detonate on the 2nd ARMED tick → BLAST entered on that tick, Bomb_On low after 2 ticks total.
- Assert Reset for one Clk during BLAST → next cycle State=0, all outputs 0; a held key does not place until released.
- frame_vs toggled with 1-cycle glitch-free pulses → exactly one tick per rising edge.
